// File: rtl/mod6_rr_arbiter.sv
// Six-way round-robin arbiter with a mod-6 priority pointer, per-grant hold limit
// and a mandatory one-cycle gap between grants.
module mod6_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] req,
    output logic [5:0] gnt,
    output logic [2:0] gnt_id,
    output logic       busy,
    output logic [2:0] slot,
    output logic       timeout
);

    localparam int unsigned NUM_REQ = 6;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned ID_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [ID_W-1:0]    r_gnt_id;
    logic [ID_W-1:0]    r_slot;
    logic               r_busy;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_hold_cnt;

    logic               w_found;
    logic [ID_W-1:0]    w_win;
    logic               w_owner_req;
    logic               w_hold_done;
    logic [ID_W-1:0]    w_next_slot;

    // Mod-6 increment: 5 wraps to 0, so 6 and 7 never appear.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] x);
        return (x == ID_W'(NUM_REQ - 1)) ? ID_W'(0) : ID_W'(x + ID_W'(1));
    endfunction

    // Scan requests starting at the priority pointer; first set bit wins.
    always_comb begin
        logic [ID_W-1:0] idx;
        w_found = 1'b0;
        w_win   = ID_W'(0);
        idx     = r_slot;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
            idx = wrap_inc(idx);
        end
    end

    assign w_owner_req = req[r_gnt_id];
    assign w_hold_done = (r_hold_cnt == CNT_W'(HOLD_MAX));
    assign w_next_slot = wrap_inc(r_gnt_id);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_slot     <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE, GAP: begin
                    if (w_found) begin
                        r_state    <= GRANT;
                        r_gnt      <= NUM_REQ'(1) << w_win;
                        r_gnt_id   <= w_win;
                        r_busy     <= 1'b1;
                        r_hold_cnt <= CNT_W'(1);
                    end else begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    // Only the owner's request matters; release beats revoke.
                    if (!w_owner_req || w_hold_done) begin
                        r_state   <= GAP;
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_slot    <= w_next_slot;
                        r_timeout <= w_owner_req;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = r_busy;
    assign slot    = r_slot;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_mod6_rr_arbiter.sv
// Bench for mod6_rr_arbiter: two instances (hold limits 4 and 1) compared every cycle
// against a behavioural model, plus directed checks of the documented sequences.
module tb_mod6_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [5:0] req;

    logic [5:0] gnt_a, gnt_b;
    logic [2:0] gnt_id_a, gnt_id_b, slot_a, slot_b;
    logic       busy_a, busy_b, timeout_a, timeout_b;

    int n_tests;
    int n_fail;

    mod6_rr_arbiter #(.HOLD_MAX(4)) u_dut_a (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_a), .gnt_id(gnt_id_a), .busy(busy_a), .slot(slot_a), .timeout(timeout_a)
    );

    mod6_rr_arbiter #(.HOLD_MAX(1)) u_dut_b (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_b), .gnt_id(gnt_id_b), .busy(busy_b), .slot(slot_b), .timeout(timeout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: who owns the resource (-1 = nobody), for how long, and the pointer.
    typedef struct packed {
        int   owner;
        int   held;
        int   slot;
        int   last_id;
        logic to;
    } mstate_t;

    mstate_t ma, mb;

    function automatic mstate_t mreset();
        mstate_t s;
        s.owner   = -1;
        s.held    = 0;
        s.slot    = 0;
        s.last_id = 0;
        s.to      = 1'b0;
        return s;
    endfunction

    function automatic mstate_t mstep(input mstate_t s, input logic [5:0] r, input int hmax);
        mstate_t n;
        logic    found;
        n     = s;
        n.to  = 1'b0;
        found = 1'b0;
        if (s.owner >= 0) begin
            if (!r[s.owner] || s.held == hmax) begin
                n.to    = r[s.owner];
                n.owner = -1;
                n.slot  = (s.owner + 1) % 6;
            end else begin
                n.held = s.held + 1;
            end
        end else begin
            for (int k = 0; k < 6; k++) begin
                int c;
                c = (s.slot + k) % 6;
                if (!found && r[c]) begin
                    found     = 1'b1;
                    n.owner   = c;
                    n.held    = 1;
                    n.last_id = c;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [5:0] mgnt(input mstate_t s);
        logic [5:0] g;
        g = '0;
        if (s.owner >= 0) g[s.owner] = 1'b1;
        return g;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a.gnt",     32'(gnt_a),     32'(mgnt(ma)));
        chk("a.gnt_id",  32'(gnt_id_a),  32'(ma.last_id));
        chk("a.slot",    32'(slot_a),    32'(ma.slot));
        chk("a.busy",    32'(busy_a),    32'(ma.owner >= 0));
        chk("a.timeout", 32'(timeout_a), 32'(ma.to));
        chk("b.gnt",     32'(gnt_b),     32'(mgnt(mb)));
        chk("b.gnt_id",  32'(gnt_id_b),  32'(mb.last_id));
        chk("b.slot",    32'(slot_b),    32'(mb.slot));
        chk("b.busy",    32'(busy_b),    32'(mb.owner >= 0));
        chk("b.timeout", 32'(timeout_b), 32'(mb.to));
    endtask

    // Drive req, take one clock edge, advance the model, then sample outputs.
    task automatic step(input logic [5:0] r);
        req = r;
        @(posedge clk);
        if (rst) begin
            ma = mreset();
            mb = mreset();
        end else begin
            ma = mstep(ma, r, 4);
            mb = mstep(mb, r, 1);
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(6'b000000);
        rst = 1'b0;
    endtask

    logic [5:0] rr;
    logic [5:0] prev;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        req     = '0;
        rst     = 1'b1;
        ma      = mreset();
        mb      = mreset();

        // Reset state
        step(6'b000000);
        step(6'b111111);
        chk("rst.gnt",  32'(gnt_a),  32'h0);
        chk("rst.slot", 32'(slot_a), 32'h0);
        rst = 1'b0;

        // Single requester for three cycles
        for (int i = 0; i < 3; i++) begin
            step(6'b000100);
            chk("single.gnt", 32'(gnt_a), 32'h04);
        end
        step(6'b000000);
        chk("single.gap",    32'(gnt_a),    32'h0);
        chk("single.slot",   32'(slot_a),   32'd3);
        chk("single.gnt_id", 32'(gnt_id_a), 32'd2);
        step(6'b000000);

        // Everybody requesting, each owner releases after two cycles
        do_reset();
        for (int i = 0; i < 7; i++) begin
            int w;
            w = i % 6;
            step(6'b111111);
            chk("all.gnt1", 32'(gnt_a), 32'(6'b000001 << w));
            step(6'b111111);
            chk("all.gnt2", 32'(gnt_a), 32'(6'b000001 << w));
            rr = 6'b111111;
            rr[w] = 1'b0;
            step(rr);
            chk("all.gap",  32'(gnt_a),  32'h0);
            chk("all.slot", 32'(slot_a), 32'((w + 1) % 6));
        end

        // Revocation by hold limit, single requester held high
        do_reset();
        for (int j = 0; j < 15; j++) begin
            step(6'b000001);
            chk("to.gnt",     32'(gnt_a),     (j % 5 < 4) ? 32'h1 : 32'h0);
            chk("to.timeout", 32'(timeout_a), (j % 5 == 4) ? 32'h1 : 32'h0);
        end

        // Fairness after revoke, starting with the pointer at 5
        do_reset();
        step(6'b010000);
        step(6'b000000);
        chk("fair.slot0", 32'(slot_a), 32'd5);
        for (int j = 0; j < 20; j++) begin
            int w;
            w = ((j / 5) % 2 == 0) ? 5 : 0;
            step(6'b100001);
            if (j % 5 < 4) begin
                chk("fair.gnt", 32'(gnt_a), 32'(6'b000001 << w));
            end else begin
                chk("fair.gap",  32'(gnt_a),     32'h0);
                chk("fair.to",   32'(timeout_a), 32'h1);
                chk("fair.slot", 32'(slot_a),    32'((w + 1) % 6));
            end
        end

        // Other requesters toggling while requester 3 owns the grant
        do_reset();
        step(6'b001000);
        chk("ign.gnt0", 32'(gnt_a), 32'h08);
        for (int j = 0; j < 3; j++) begin
            step((j % 2 == 0) ? 6'b111111 : 6'b001000);
            chk("ign.gnt", 32'(gnt_a), 32'h08);
        end
        step(6'b110111);
        chk("ign.rel", 32'(gnt_a),     32'h0);
        chk("ign.to",  32'(timeout_a), 32'h0);
        step(6'b000000);

        // Asynchronous reset while a grant is active
        step(6'b000010);
        chk("arst.pre", 32'(gnt_a), 32'h02);
        #1;
        rst = 1'b1;
        ma  = mreset();
        mb  = mreset();
        #1;
        chk("arst.gnt_a", 32'(gnt_a),  32'h0);
        chk("arst.gnt_b", 32'(gnt_b),  32'h0);
        chk("arst.busy",  32'(busy_a), 32'h0);
        #1;
        rst = 1'b0;
        step(6'b000000);
        chk("arst.slot",   32'(slot_a),    32'h0);
        chk("arst.gnt_id", 32'(gnt_id_a),  32'h0);
        chk("arst.to",     32'(timeout_a), 32'h0);
        step(6'b100010);
        chk("arst.regnt", 32'(gnt_a), 32'h02);

        // Random traffic; requests are often held to exercise long grants
        prev = '0;
        for (int j = 0; j < 400; j++) begin
            rr = ($urandom_range(0, 3) != 0) ? prev : 6'($urandom);
            prev = rr;
            step(rr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
